// File: rtl/midi_pkg.sv
// Shared MIDI constants: status type codes, byte-class thresholds, controller
// numbers and the parser state encoding.
package midi_pkg;

  localparam logic [3:0] ST_NOTE_OFF   = 4'h8;
  localparam logic [3:0] ST_NOTE_ON    = 4'h9;
  localparam logic [3:0] ST_CTRL_CHG   = 4'hB;
  localparam logic [3:0] ST_PROG_CHG   = 4'hC;
  localparam logic [3:0] ST_CHAN_PRESS = 4'hD;

  localparam logic [7:0] SYS_COMMON_MIN = 8'hF0;
  localparam logic [7:0] REALTIME_MIN   = 8'hF8;

  localparam logic [6:0] CC_ALL_SOUND_OFF = 7'd120;
  localparam logic [6:0] CC_ALL_NOTES_OFF = 7'd123;

  typedef enum logic [1:0] {
    NO_STATUS = 2'd0,
    WAIT_D1   = 2'd1,
    WAIT_D2   = 2'd2
  } midi_state_t;

  // Program change and channel pressure carry a single data byte.
  function automatic logic one_data_byte(input logic [3:0] status_type);
    return (status_type == ST_PROG_CHG) || (status_type == ST_CHAN_PRESS);
  endfunction

endpackage

// File: rtl/midi_note_decoder.sv
// Monophonic MIDI note decoder: parses a byte stream with running status and
// holds the most recent note-on for one channel.
module midi_note_decoder
  import midi_pkg::*;
#(
  parameter logic [3:0] CHANNEL = 4'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  output logic [7:0] note_o,
  output logic [6:0] velocity_o,
  output logic       gate_o,
  output logic       event_o
);

  midi_state_t state_q, state_d;
  logic [7:0]  run_status_q, run_status_d;
  logic [6:0]  data1_q, data1_d;

  logic        is_realtime, is_sys_common, is_status, is_data;
  logic        msg_done;
  logic [6:0]  msg_d1, msg_d2;

  logic [7:0]  note_d;
  logic [6:0]  velocity_d;
  logic        gate_d;
  logic        event_d;

  assign is_realtime   = (byte_i >= REALTIME_MIN);
  assign is_sys_common = (byte_i >= SYS_COMMON_MIN) && !is_realtime;
  assign is_status     = byte_i[7] && (byte_i < SYS_COMMON_MIN);
  assign is_data       = !byte_i[7];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= NO_STATUS;
      run_status_q <= '0;
      data1_q      <= '0;
      note_o       <= '0;
      velocity_o   <= '0;
      gate_o       <= 1'b0;
      event_o      <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_status_q <= run_status_d;
      data1_q      <= data1_d;
      note_o       <= note_d;
      velocity_o   <= velocity_d;
      gate_o       <= gate_d;
      event_o      <= event_d;
    end
  end

  // Realtime bytes fall through every branch and leave the parser untouched.
  always_comb begin
    state_d      = state_q;
    run_status_d = run_status_q;
    data1_d      = data1_q;
    msg_done     = 1'b0;
    msg_d1       = '0;
    msg_d2       = '0;
    if (byte_valid_i) begin
      if (is_status) begin
        run_status_d = byte_i;
        state_d      = WAIT_D1;
      end else if (is_sys_common) begin
        run_status_d = '0;
        state_d      = NO_STATUS;
      end else if (is_data) begin
        unique case (state_q)
          WAIT_D1: begin
            if (one_data_byte(run_status_q[7:4])) begin
              msg_done = 1'b1;
              msg_d1   = byte_i[6:0];
            end else begin
              data1_d = byte_i[6:0];
              state_d = WAIT_D2;
            end
          end
          WAIT_D2: begin
            msg_done = 1'b1;
            msg_d1   = data1_q;
            msg_d2   = byte_i[6:0];
            state_d  = WAIT_D1;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    note_d     = note_o;
    velocity_d = velocity_o;
    gate_d     = gate_o;
    if (msg_done && (run_status_q[3:0] == CHANNEL)) begin
      unique case (run_status_q[7:4])
        ST_NOTE_ON: begin
          if (msg_d2 != 7'd0) begin
            if (msg_d1 != 7'd0) begin
              note_d     = {1'b0, msg_d1};
              velocity_d = msg_d2;
              gate_d     = 1'b1;
            end
          end else if ({1'b0, msg_d1} == note_o) begin
            note_d     = '0;
            velocity_d = '0;
            gate_d     = 1'b0;
          end
        end
        ST_NOTE_OFF: begin
          if ({1'b0, msg_d1} == note_o) begin
            note_d     = '0;
            velocity_d = '0;
            gate_d     = 1'b0;
          end
        end
        ST_CTRL_CHG: begin
          if ((msg_d1 == CC_ALL_SOUND_OFF) || (msg_d1 == CC_ALL_NOTES_OFF)) begin
            note_d     = '0;
            velocity_d = '0;
            gate_d     = 1'b0;
          end
        end
        default: ;
      endcase
    end
    event_d = (note_d != note_o) || (gate_d != gate_o);
  end

endmodule

// File: tb/tb_midi_note_decoder.sv
// Directed and randomized byte-stream test of midi_note_decoder against a
// message-level reference model.
module tb_midi_note_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_i = 8'h00;
  logic       byte_valid_i = 1'b0;
  logic [7:0] note_o;
  logic [6:0] velocity_o;
  logic       gate_o;
  logic       event_o;

  int errors = 0;
  int checks = 0;

  localparam int CH = 0;

  midi_note_decoder #(.CHANNEL(4'd0)) dut (
    .clk          (clk),
    .rst          (rst),
    .byte_i       (byte_i),
    .byte_valid_i (byte_valid_i),
    .note_o       (note_o),
    .velocity_o   (velocity_o),
    .gate_o       (gate_o),
    .event_o      (event_o)
  );

  always #5 clk = ~clk;

  // Reference model: running status plus a list of collected data bytes.
  int m_rs;
  int m_data[$];
  int m_note, m_vel, m_gate, m_evt;

  function automatic void model_reset();
    m_rs = 0;
    m_data.delete();
    m_note = 0; m_vel = 0; m_gate = 0; m_evt = 0;
  endfunction

  function automatic void model_message(int st, int d1, int d2);
    int old_note, old_gate, kind;
    old_note = m_note;
    old_gate = m_gate;
    kind = st / 16;
    if (st % 16 == CH) begin
      if (kind == 9 && d2 > 0) begin
        if (d1 > 0) begin m_note = d1; m_vel = d2; m_gate = 1; end
      end else if (kind == 8 || kind == 9) begin
        if (d1 == m_note) begin m_note = 0; m_vel = 0; m_gate = 0; end
      end else if (kind == 11 && (d1 == 120 || d1 == 123)) begin
        m_note = 0; m_vel = 0; m_gate = 0;
      end
    end
    m_evt = (m_note != old_note || m_gate != old_gate) ? 1 : 0;
  endfunction

  function automatic void model_byte(int b);
    int need;
    m_evt = 0;
    if (b >= 248) return;
    if (b >= 240) begin m_rs = 0; m_data.delete(); return; end
    if (b >= 128) begin m_rs = b; m_data.delete(); return; end
    if (m_rs == 0) return;
    need = (m_rs / 16 == 12 || m_rs / 16 == 13) ? 1 : 2;
    m_data.push_back(b);
    if (m_data.size() == need) begin
      model_message(m_rs, m_data[0], (need == 2) ? m_data[1] : 0);
      m_data.delete();
    end
  endfunction

  task automatic check_all(input string tag);
    checks++;
    assert (note_o === m_note[7:0]) else begin
      errors++;
      $error("FAIL %s note_o observed=%0h expected=%0h", tag, note_o, m_note[7:0]);
    end
    checks++;
    assert (velocity_o === m_vel[6:0]) else begin
      errors++;
      $error("FAIL %s velocity_o observed=%0h expected=%0h", tag, velocity_o, m_vel[6:0]);
    end
    checks++;
    assert (gate_o === m_gate[0]) else begin
      errors++;
      $error("FAIL %s gate_o observed=%0b expected=%0b", tag, gate_o, m_gate[0]);
    end
    checks++;
    assert (event_o === m_evt[0]) else begin
      errors++;
      $error("FAIL %s event_o observed=%0b expected=%0b", tag, event_o, m_evt[0]);
    end
  endtask

  task automatic send(input logic [7:0] b, input string tag);
    @(negedge clk);
    byte_i = b;
    byte_valid_i = 1'b1;
    @(posedge clk);
    #1;
    byte_valid_i = 1'b0;
    model_byte(int'(b));
    check_all($sformatf("%s byte=%02h", tag, b));
  endtask

  task automatic idle(input string tag);
    @(negedge clk);
    byte_valid_i = 1'b0;
    @(posedge clk);
    #1;
    m_evt = 0;
    check_all(tag);
  endtask

  // Reset is applied with a valid byte present to exercise reset priority.
  task automatic do_reset(input logic [7:0] b, input string tag);
    @(negedge clk);
    rst = 1'b1;
    byte_i = b;
    byte_valid_i = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    byte_valid_i = 1'b0;
    model_reset();
    check_all(tag);
  endtask

  function automatic logic [7:0] rand_byte();
    int p;
    logic [7:0] kinds [5];
    kinds[0] = 8'h80; kinds[1] = 8'h90; kinds[2] = 8'hB0;
    kinds[3] = 8'hC0; kinds[4] = 8'hD0;
    p = $urandom_range(0, 99);
    if (p < 18) return kinds[$urandom_range(0, 4)] | 8'($urandom_range(0, 1));
    if (p < 22) return 8'(248 + $urandom_range(0, 7));
    if (p < 24) return 8'(240 + $urandom_range(0, 7));
    if (p < 28) return ($urandom_range(0, 1) != 0) ? 8'd120 : 8'd123;
    if (p < 36) return 8'($urandom_range(0, 127));
    return 8'($urandom_range(0, 5));
  endfunction

  initial begin
    int r;
    model_reset();
    do_reset(8'h90, "reset");
    idle("reset idle");

    send(8'h90, "basic"); send(8'h3C, "basic"); send(8'h64, "basic");
    idle("basic pulse end");

    send(8'h3E, "running"); send(8'h50, "running");
    send(8'h80, "noteoff other"); send(8'h3C, "noteoff other"); send(8'h00, "noteoff other");
    send(8'h3E, "rs noteoff"); send(8'h00, "rs noteoff");
    idle("rs noteoff end");

    send(8'h90, "realtime"); send(8'hF8, "realtime"); send(8'h3C, "realtime");
    send(8'hFE, "realtime"); send(8'h64, "realtime");

    send(8'h91, "other chan"); send(8'h45, "other chan"); send(8'h64, "other chan");
    send(8'hC0, "progchg"); send(8'h05, "progchg"); send(8'h3C, "progchg"); send(8'h64, "progchg");

    send(8'h90, "note0"); send(8'h00, "note0"); send(8'h40, "note0");
    send(8'hB0, "cc123"); send(8'h7B, "cc123"); send(8'h00, "cc123");
    send(8'h90, "cc120"); send(8'h30, "cc120"); send(8'h22, "cc120");
    send(8'hB0, "cc120"); send(8'h78, "cc120"); send(8'h7F, "cc120");
    send(8'h90, "sys"); send(8'h3C, "sys"); send(8'h64, "sys");
    send(8'hB0, "sys"); send(8'h7B, "sys"); send(8'h00, "sys");
    send(8'hF0, "sys"); send(8'h3C, "sys"); send(8'h64, "sys");

    send(8'h90, "abort"); send(8'h3C, "abort"); send(8'h80, "abort");
    send(8'h3C, "abort"); send(8'h64, "abort");

    do_reset(8'h00, "pre rst mid");
    send(8'h90, "rst mid"); send(8'h3C, "rst mid");
    do_reset(8'h64, "rst mid");
    send(8'h64, "rst mid"); send(8'h3C, "rst mid"); send(8'h64, "rst mid");
    idle("rst mid end");

    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 2) do_reset(8'($urandom_range(0, 255)), "rand reset");
      else if (r < 8) idle("rand idle");
      else send(rand_byte(), "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
